// File: rtl/spi_arb_pkg.sv
// Shared state encoding and owner identifiers for the SPI flash arbiter.
package spi_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_OWN_DSP = 2'b01,
        ST_OWN_CPU = 2'b10,
        ST_GUARD   = 2'b11
    } arb_state_t;

    localparam logic OWNER_DSP = 1'b0;
    localparam logic OWNER_CPU = 1'b1;

endpackage

// File: rtl/sync_ff.sv
// Multi-stage synchroniser that resets to 1 so an idle active-low chip select
// never looks like a request while reset is releasing.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/spi_flash_arbiter.sv
// Shares one SPI flash between the DSP and CPU masters: grant on chip-select
// assertion, hold until release, then a guard gap before the next owner.
module spi_flash_arbiter
    import spi_arb_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int GUARD_CYCLES   = 8,
    parameter int TIMEOUT_CYCLES = 2**20,
    parameter int DSP_FIRST      = 1
) (
    input  logic       sysclk,
    input  logic       reset_INV,
    input  logic       enable,
    input  logic       dsp_spi_clk,
    input  logic       dsp_spi_mosi,
    input  logic       dsp_spi_cs_INV,
    output logic       dsp_spi_miso,
    input  logic       cpu_spi_clk,
    input  logic       cpu_spi_mosi,
    input  logic       cpu_spi_cs_INV,
    output logic       cpu_spi_miso,
    output logic       spi_flash_clk,
    output logic       spi_flash_mosi,
    output logic       spi_flash_cs_INV,
    input  logic       spi_flash_miso,
    output logic       dsp_grant,
    output logic       cpu_grant,
    output logic       dsp_denied,
    output logic       cpu_denied,
    output logic [7:0] conflict_count,
    output logic       timeout_flag,
    output logic [1:0] state
);

    localparam int               HOLD_W         = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX      = HOLD_W'(TIMEOUT_CYCLES);
    localparam logic [7:0]       GUARD_LOAD     = 8'(GUARD_CYCLES - 1);
    localparam logic             LAST_OWNER_RST = (DSP_FIRST != 0) ? OWNER_CPU : OWNER_DSP;

    logic dsp_cs_sync, cpu_cs_sync;
    logic dsp_req, cpu_req;

    sync_ff #(.STAGES(SYNC_STAGES)) u_dsp_sync (
        .clk(sysclk), .rst_n(reset_INV), .d(dsp_spi_cs_INV), .q(dsp_cs_sync)
    );
    sync_ff #(.STAGES(SYNC_STAGES)) u_cpu_sync (
        .clk(sysclk), .rst_n(reset_INV), .d(cpu_spi_cs_INV), .q(cpu_cs_sync)
    );

    assign dsp_req = ~dsp_cs_sync;
    assign cpu_req = ~cpu_cs_sync;

    arb_state_t        state_q, state_d;
    logic [7:0]        guard_q, guard_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              last_owner_q, last_owner_d;
    logic              timeout_q, timeout_d;
    logic              dsp_grant_q, dsp_grant_d, cpu_grant_q, cpu_grant_d;
    logic              dsp_denied_q, dsp_denied_d, cpu_denied_q, cpu_denied_d;
    logic [7:0]        conflict_q, conflict_d;
    logic              denial_start;

    always_comb begin
        state_d      = state_q;
        guard_d      = guard_q;
        hold_d       = hold_q;
        last_owner_d = last_owner_q;
        case (state_q)
            ST_IDLE: begin
                hold_d = '0;
                if (enable) begin
                    // Under contention the requester that did not own last wins.
                    if (dsp_req && (!cpu_req || last_owner_q == OWNER_CPU)) begin
                        state_d = ST_OWN_DSP;
                    end else if (cpu_req) begin
                        state_d = ST_OWN_CPU;
                    end
                end
            end
            ST_OWN_DSP: begin
                if (!dsp_req || !enable) begin
                    state_d      = ST_GUARD;
                    guard_d      = GUARD_LOAD;
                    last_owner_d = OWNER_DSP;
                end else if (hold_q != HOLD_MAX) begin
                    hold_d = hold_q + 1'b1;
                end
            end
            ST_OWN_CPU: begin
                if (!cpu_req || !enable) begin
                    state_d      = ST_GUARD;
                    guard_d      = GUARD_LOAD;
                    last_owner_d = OWNER_CPU;
                end else if (hold_q != HOLD_MAX) begin
                    hold_d = hold_q + 1'b1;
                end
            end
            ST_GUARD: begin
                if (guard_q == 8'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    guard_d = guard_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        timeout_d    = timeout_q | (hold_d == HOLD_MAX);
        dsp_grant_d  = (state_d == ST_OWN_DSP);
        cpu_grant_d  = (state_d == ST_OWN_CPU);
        dsp_denied_d = dsp_req && (state_d == ST_OWN_CPU || state_d == ST_GUARD);
        cpu_denied_d = cpu_req && (state_d == ST_OWN_DSP || state_d == ST_GUARD);

        // Simultaneous rises of both denials count as a single conflict.
        denial_start = (dsp_denied_d && !dsp_denied_q) || (cpu_denied_d && !cpu_denied_q);
        conflict_d   = conflict_q;
        if (denial_start && conflict_q != 8'hFF) begin
            conflict_d = conflict_q + 1'b1;
        end
    end

    always_ff @(posedge sysclk or negedge reset_INV) begin
        if (!reset_INV) begin
            state_q      <= ST_IDLE;
            guard_q      <= '0;
            hold_q       <= '0;
            last_owner_q <= LAST_OWNER_RST;
            timeout_q    <= 1'b0;
            dsp_grant_q  <= 1'b0;
            cpu_grant_q  <= 1'b0;
            dsp_denied_q <= 1'b0;
            cpu_denied_q <= 1'b0;
            conflict_q   <= '0;
        end else begin
            state_q      <= state_d;
            guard_q      <= guard_d;
            hold_q       <= hold_d;
            last_owner_q <= last_owner_d;
            timeout_q    <= timeout_d;
            dsp_grant_q  <= dsp_grant_d;
            cpu_grant_q  <= cpu_grant_d;
            dsp_denied_q <= dsp_denied_d;
            cpu_denied_q <= cpu_denied_d;
            conflict_q   <= conflict_d;
        end
    end

    always_comb begin
        spi_flash_clk    = 1'b0;
        spi_flash_mosi   = 1'b0;
        spi_flash_cs_INV = 1'b1;
        dsp_spi_miso     = 1'b0;
        cpu_spi_miso     = 1'b0;
        if (dsp_grant_q) begin
            spi_flash_clk    = dsp_spi_clk;
            spi_flash_mosi   = dsp_spi_mosi;
            spi_flash_cs_INV = dsp_spi_cs_INV;
            dsp_spi_miso     = spi_flash_miso;
        end else if (cpu_grant_q) begin
            spi_flash_clk    = cpu_spi_clk;
            spi_flash_mosi   = cpu_spi_mosi;
            spi_flash_cs_INV = cpu_spi_cs_INV;
            cpu_spi_miso     = spi_flash_miso;
        end
    end

    assign dsp_grant      = dsp_grant_q;
    assign cpu_grant      = cpu_grant_q;
    assign dsp_denied     = dsp_denied_q;
    assign cpu_denied     = cpu_denied_q;
    assign conflict_count = conflict_q;
    assign timeout_flag   = timeout_q;
    assign state          = state_q;

endmodule

// File: tb/tb_spi_flash_arbiter.sv
// Directed self-checking bench for the SPI flash arbiter.
module tb_spi_flash_arbiter;

    logic       sysclk;
    logic       reset_INV;
    logic       enable;
    logic       dsp_spi_clk, dsp_spi_mosi, dsp_spi_cs_INV, dsp_spi_miso;
    logic       cpu_spi_clk, cpu_spi_mosi, cpu_spi_cs_INV, cpu_spi_miso;
    logic       spi_flash_clk, spi_flash_mosi, spi_flash_cs_INV, spi_flash_miso;
    logic       dsp_grant, cpu_grant, dsp_denied, cpu_denied;
    logic [7:0] conflict_count;
    logic       timeout_flag;
    logic [1:0] state;

    int total = 0;
    int bad   = 0;

    spi_flash_arbiter #(
        .SYNC_STAGES(2), .GUARD_CYCLES(8), .TIMEOUT_CYCLES(16), .DSP_FIRST(1)
    ) dut (
        .sysclk(sysclk), .reset_INV(reset_INV), .enable(enable),
        .dsp_spi_clk(dsp_spi_clk), .dsp_spi_mosi(dsp_spi_mosi),
        .dsp_spi_cs_INV(dsp_spi_cs_INV), .dsp_spi_miso(dsp_spi_miso),
        .cpu_spi_clk(cpu_spi_clk), .cpu_spi_mosi(cpu_spi_mosi),
        .cpu_spi_cs_INV(cpu_spi_cs_INV), .cpu_spi_miso(cpu_spi_miso),
        .spi_flash_clk(spi_flash_clk), .spi_flash_mosi(spi_flash_mosi),
        .spi_flash_cs_INV(spi_flash_cs_INV), .spi_flash_miso(spi_flash_miso),
        .dsp_grant(dsp_grant), .cpu_grant(cpu_grant),
        .dsp_denied(dsp_denied), .cpu_denied(cpu_denied),
        .conflict_count(conflict_count), .timeout_flag(timeout_flag), .state(state)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    task automatic tick(input int n);
        repeat (n) @(negedge sysclk);
    endtask

    task automatic do_reset();
        @(negedge sysclk);
        reset_INV = 1'b0;
        dsp_spi_cs_INV = 1'b1; cpu_spi_cs_INV = 1'b1;
        dsp_spi_clk = 1'b0; dsp_spi_mosi = 1'b0;
        cpu_spi_clk = 1'b0; cpu_spi_mosi = 1'b0;
        spi_flash_miso = 1'b0; enable = 1'b1;
        tick(2);
        reset_INV = 1'b1;
        tick(1);
    endtask

    task automatic test_reset();
        reset_INV = 1'b0; enable = 1'b1;
        dsp_spi_cs_INV = 1'b1; cpu_spi_cs_INV = 1'b1;
        dsp_spi_clk = 1'b0; dsp_spi_mosi = 1'b0;
        cpu_spi_clk = 1'b0; cpu_spi_mosi = 1'b0;
        spi_flash_miso = 1'b1;
        tick(3);
        total++; if (state !== 2'b00) begin bad++; $display("FAIL reset_state: got %b want 00", state); end
        total++; if ({dsp_grant, cpu_grant, dsp_denied, cpu_denied} !== 4'b0000) begin bad++;
            $display("FAIL reset_flags: got %b want 0000", {dsp_grant, cpu_grant, dsp_denied, cpu_denied}); end
        total++; if (conflict_count !== 8'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", conflict_count); end
        total++; if (timeout_flag !== 1'b0) begin bad++; $display("FAIL reset_timeout: got %b want 0", timeout_flag); end
        total++; if ({spi_flash_cs_INV, spi_flash_clk, spi_flash_mosi} !== 3'b100) begin bad++;
            $display("FAIL reset_flash_pins: got %b want 100", {spi_flash_cs_INV, spi_flash_clk, spi_flash_mosi}); end
        total++; if ({dsp_spi_miso, cpu_spi_miso} !== 2'b00) begin bad++;
            $display("FAIL reset_miso: got %b want 00", {dsp_spi_miso, cpu_spi_miso}); end
        spi_flash_miso = 1'b0;
        reset_INV = 1'b1;
        tick(1);
        $display("test_reset: done");
    endtask

    task automatic test_single_dsp();
        dsp_spi_cs_INV = 1'b0; dsp_spi_clk = 1'b1; dsp_spi_mosi = 1'b1; spi_flash_miso = 1'b1;
        tick(2);
        total++; if (dsp_grant !== 1'b0 || spi_flash_cs_INV !== 1'b1) begin bad++;
            $display("FAIL single_early: grant=%b cs=%b want 0,1", dsp_grant, spi_flash_cs_INV); end
        tick(1);
        total++; if (dsp_grant !== 1'b1 || state !== 2'b01) begin bad++;
            $display("FAIL single_grant: grant=%b state=%b want 1,01", dsp_grant, state); end
        total++; if ({spi_flash_cs_INV, spi_flash_clk, spi_flash_mosi} !== 3'b011) begin bad++;
            $display("FAIL single_pins: got %b want 011", {spi_flash_cs_INV, spi_flash_clk, spi_flash_mosi}); end
        total++; if ({dsp_spi_miso, cpu_spi_miso} !== 2'b10) begin bad++;
            $display("FAIL single_miso: got %b want 10", {dsp_spi_miso, cpu_spi_miso}); end
        dsp_spi_clk = 1'b0; dsp_spi_mosi = 1'b0; #1;
        total++; if ({spi_flash_clk, spi_flash_mosi} !== 2'b00) begin bad++;
            $display("FAIL single_follow: got %b want 00", {spi_flash_clk, spi_flash_mosi}); end
        tick(1);
        dsp_spi_cs_INV = 1'b1;
        tick(3);
        for (int i = 0; i < 8; i++) begin
            total++; if (state !== 2'b11 || spi_flash_cs_INV !== 1'b1) begin bad++;
                $display("FAIL single_guard[%0d]: state=%b cs=%b want 11,1", i, state, spi_flash_cs_INV); end
            tick(1);
        end
        total++; if (state !== 2'b00) begin bad++; $display("FAIL single_idle: got %b want 00", state); end
        spi_flash_miso = 1'b0;
        $display("test_single_dsp: done");
    endtask

    task automatic test_simultaneous();
        do_reset();
        dsp_spi_cs_INV = 1'b0; cpu_spi_cs_INV = 1'b0;
        tick(3);
        total++; if ({dsp_grant, cpu_grant} !== 2'b10) begin bad++;
            $display("FAIL simul_grant: got %b want 10", {dsp_grant, cpu_grant}); end
        total++; if ({dsp_denied, cpu_denied} !== 2'b01) begin bad++;
            $display("FAIL simul_denied: got %b want 01", {dsp_denied, cpu_denied}); end
        total++; if (conflict_count !== 8'd1) begin bad++; $display("FAIL simul_count: got %0d want 1", conflict_count); end
        dsp_spi_cs_INV = 1'b1;
        tick(3);
        total++; if (state !== 2'b11 || cpu_denied !== 1'b1 || conflict_count !== 8'd1) begin bad++;
            $display("FAIL simul_guard: state=%b denied=%b count=%0d want 11,1,1", state, cpu_denied, conflict_count); end
        tick(8);
        total++; if (state !== 2'b00) begin bad++; $display("FAIL simul_idle: got %b want 00", state); end
        tick(1);
        total++; if ({dsp_grant, cpu_grant} !== 2'b01 || state !== 2'b10 || spi_flash_cs_INV !== 1'b0) begin bad++;
            $display("FAIL simul_cpu: grants=%b state=%b cs=%b want 01,10,0", {dsp_grant, cpu_grant}, state, spi_flash_cs_INV); end
        cpu_spi_cs_INV = 1'b1;
        tick(12);
        $display("test_simultaneous: done");
    endtask

    task automatic test_back_to_back();
        logic exp_dsp;
        do_reset();
        dsp_spi_cs_INV = 1'b0; cpu_spi_cs_INV = 1'b0;
        for (int t = 0; t < 4; t++) begin
            exp_dsp = (t % 2 == 0);
            for (int k = 0; k < 40; k++) begin
                if (dsp_grant || cpu_grant) break;
                tick(1);
            end
            total++; if (dsp_grant !== exp_dsp || cpu_grant !== ~exp_dsp) begin bad++;
                $display("FAIL b2b_grant[%0d]: got %b want %b", t, {dsp_grant, cpu_grant}, {exp_dsp, ~exp_dsp}); end
            $display("b2b transfer %0d: grants=%b count=%0d", t, {dsp_grant, cpu_grant}, conflict_count);
            if (t > 0) begin
                if (exp_dsp) cpu_spi_cs_INV = 1'b0;
                else         dsp_spi_cs_INV = 1'b0;
            end
            tick(5);
            if (exp_dsp) dsp_spi_cs_INV = 1'b1;
            else         cpu_spi_cs_INV = 1'b1;
            tick(3);
        end
        total++; if (conflict_count !== 8'd4) begin bad++; $display("FAIL b2b_count: got %0d want 4", conflict_count); end
        dsp_spi_cs_INV = 1'b1; cpu_spi_cs_INV = 1'b1;
        tick(15);
        $display("test_back_to_back: done");
    endtask

    task automatic test_saturation();
        do_reset();
        cpu_spi_cs_INV = 1'b0;
        tick(3);
        total++; if (cpu_grant !== 1'b1) begin bad++; $display("FAIL sat_owner: got %b want 1", cpu_grant); end
        for (int i = 0; i < 300; i++) begin
            dsp_spi_cs_INV = 1'b0; tick(3);
            dsp_spi_cs_INV = 1'b1; tick(3);
            if (i == 9) begin
                total++; if (conflict_count !== 8'd10) begin bad++; $display("FAIL sat_mid: got %0d want 10", conflict_count); end
            end
        end
        total++; if (conflict_count !== 8'hFF) begin bad++; $display("FAIL sat_full: got %0d want 255", conflict_count); end
        for (int i = 0; i < 10; i++) begin
            dsp_spi_cs_INV = 1'b0; tick(3);
            dsp_spi_cs_INV = 1'b1; tick(3);
        end
        total++; if (conflict_count !== 8'hFF || cpu_grant !== 1'b1) begin bad++;
            $display("FAIL sat_hold: count=%0d grant=%b want 255,1", conflict_count, cpu_grant); end
        cpu_spi_cs_INV = 1'b1;
        tick(15);
        $display("test_saturation: done");
    endtask

    task automatic test_timeout();
        do_reset();
        total++; if (timeout_flag !== 1'b0) begin bad++; $display("FAIL to_start: got %b want 0", timeout_flag); end
        dsp_spi_cs_INV = 1'b0;
        tick(3);
        total++; if (dsp_grant !== 1'b1) begin bad++; $display("FAIL to_grant: got %b want 1", dsp_grant); end
        tick(15);
        total++; if (timeout_flag !== 1'b0) begin bad++; $display("FAIL to_early: got %b want 0", timeout_flag); end
        tick(1);
        total++; if (timeout_flag !== 1'b1 || dsp_grant !== 1'b1) begin bad++;
            $display("FAIL to_set: flag=%b grant=%b want 1,1", timeout_flag, dsp_grant); end
        dsp_spi_cs_INV = 1'b1;
        tick(15);
        total++; if (timeout_flag !== 1'b1 || state !== 2'b00) begin bad++;
            $display("FAIL to_sticky: flag=%b state=%b want 1,00", timeout_flag, state); end
        do_reset();
        total++; if (timeout_flag !== 1'b0) begin bad++; $display("FAIL to_clear: got %b want 0", timeout_flag); end
        $display("test_timeout: done");
    endtask

    task automatic test_enable_and_reset();
        do_reset();
        cpu_spi_cs_INV = 1'b0; cpu_spi_clk = 1'b1; cpu_spi_mosi = 1'b1;
        tick(3);
        total++; if (cpu_grant !== 1'b1 || spi_flash_cs_INV !== 1'b0) begin bad++;
            $display("FAIL en_grant: grant=%b cs=%b want 1,0", cpu_grant, spi_flash_cs_INV); end
        enable = 1'b0;
        tick(1);
        total++; if (state !== 2'b11 || spi_flash_cs_INV !== 1'b1 || cpu_grant !== 1'b0) begin bad++;
            $display("FAIL en_drop: state=%b cs=%b grant=%b want 11,1,0", state, spi_flash_cs_INV, cpu_grant); end
        enable = 1'b1;
        tick(9);
        total++; if (cpu_grant !== 1'b1 || state !== 2'b10) begin bad++;
            $display("FAIL en_regrant: grant=%b state=%b want 1,10", cpu_grant, state); end
        spi_flash_miso = 1'b1; #1;
        total++; if ({dsp_spi_miso, cpu_spi_miso} !== 2'b01) begin bad++;
            $display("FAIL en_miso: got %b want 01", {dsp_spi_miso, cpu_spi_miso}); end
        #1 reset_INV = 1'b0;
        #1;
        total++; if (state !== 2'b00 || {dsp_grant, cpu_grant, dsp_denied, cpu_denied} !== 4'b0000) begin bad++;
            $display("FAIL async_state: state=%b flags=%b want 00,0000", state, {dsp_grant, cpu_grant, dsp_denied, cpu_denied}); end
        total++; if ({spi_flash_cs_INV, spi_flash_clk, spi_flash_mosi, cpu_spi_miso} !== 4'b1000) begin bad++;
            $display("FAIL async_pins: got %b want 1000", {spi_flash_cs_INV, spi_flash_clk, spi_flash_mosi, cpu_spi_miso}); end
        total++; if (conflict_count !== 8'd0 || timeout_flag !== 1'b0) begin bad++;
            $display("FAIL async_count: count=%0d flag=%b want 0,0", conflict_count, timeout_flag); end
        cpu_spi_cs_INV = 1'b1; cpu_spi_clk = 1'b0; cpu_spi_mosi = 1'b0; spi_flash_miso = 1'b0;
        tick(2);
        reset_INV = 1'b1;
        tick(2);
        $display("test_enable_and_reset: done");
    endtask

    initial begin
        test_reset();
        test_single_dsp();
        test_simultaneous();
        test_back_to_back();
        test_saturation();
        test_timeout();
        test_enable_and_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_flash_arbiter.md
Name: spi_flash_arbiter

Overview:
Shares the single 3V3 SPI boot/config flash between two SPI masters: the DSP (spi cs0) and the CPU (spi0, 1V8 bank). The block sits in the CPLD top level between the bank-level SPI pins and the flash pins, and takes over the currently unconditional DSP-only flash routing. Ownership is granted on chip-select assertion and held until release plus a guard time. Denials and over-long holds are counted and flagged for the housekeeping GPIOs and LEDs.

Parameters:
SYNC_STAGES, 2, synchroniser depth for each requester cs_INV into the sysclk domain (min 2)
GUARD_CYCLES, 8, sysclk cycles the flash cs_INV is held high between owners (1..255)
TIMEOUT_CYCLES, 2**20, sysclk cycles of continuous ownership before timeout_flag sets (about 0.2-0.3 s at 3.3-5.5 MHz)
DSP_FIRST, 1, on a simultaneous first request after reset: 1 grants DSP, 0 grants CPU

Ports:
sysclk  in  1  UFM oscillator clock, 3.3-5.5 MHz
reset_INV  in  1  asynchronous active-low reset
enable  in  1  arbitration enable (dsp_bank_enable); low forces release
dsp_spi_clk  in  1  DSP SPI clock
dsp_spi_mosi  in  1  DSP SPI data out
dsp_spi_cs_INV  in  1  DSP flash chip select, active low
dsp_spi_miso  out  1  flash data to DSP; 0 when not owner
cpu_spi_clk  in  1  CPU SPI clock
cpu_spi_mosi  in  1  CPU SPI data out
cpu_spi_cs_INV  in  1  CPU flash chip select, active low
cpu_spi_miso  out  1  flash data to CPU; 0 when not owner
spi_flash_clk  out  1  flash clock
spi_flash_mosi  out  1  flash data in
spi_flash_cs_INV  out  1  flash chip select, active low
spi_flash_miso  in  1  flash data out
dsp_grant  out  1  registered: DSP owns the flash
cpu_grant  out  1  registered: CPU owns the flash
dsp_denied  out  1  registered: DSP requesting while CPU owns or in guard
cpu_denied  out  1  registered: CPU requesting while DSP owns or in guard
conflict_count  out  8  saturating count of denied request starts
timeout_flag  out  1  sticky: an owner exceeded TIMEOUT_CYCLES
state  out  2  00 IDLE, 01 OWN_DSP, 10 OWN_CPU, 11 GUARD

Behaviour:
- Reset (async, reset_INV low) state:
  - state IDLE, grants 0, denied 0, conflict_count 0, timeout_flag 0.
  - last_owner = CPU if DSP_FIRST=1, else DSP.
  - Synchroniser flops are set to 1 (idle).
  - Flash outputs: cs_INV 1, clk 0, mosi 0. Both miso outputs 0.
- Request: dsp_req / cpu_req = synchronised cs_INV low. Latency from cs falling to grant is SYNC_STAGES+1 sysclk. System rule: a master waits at least SYNC_STAGES+2 sysclk after cs falling before its first clock edge.
- Flash pin mux (combinational on the registered grant):
  - OWN_DSP: flash clk/mosi/cs_INV = DSP inputs; dsp_spi_miso = spi_flash_miso.
  - OWN_CPU: the same, using the CPU inputs.
  - IDLE and GUARD: cs_INV 1, clk 0, mosi 0, both miso 0.
- IDLE:
  - enable low: stay in IDLE.
  - One requester: go to that requester's OWN state.
  - Both requesting: grant the requester that is not last_owner.
- OWN_x:
  - Owner's request drops, or enable drops: go to GUARD and load the guard counter with GUARD_CYCLES-1; last_owner = x.
  - Hold counter increments each cycle and saturates. On reaching TIMEOUT_CYCLES, timeout_flag is set. Ownership is never revoked because of a timeout.
- GUARD:
  - Counter decrements each cycle. At 0, go to IDLE; the IDLE decision is taken on the following cycle.
  - A pending requester is granted from IDLE, which gives round-robin fairness under contention.
- Denial: y_denied = y_req while state is the other OWN state or GUARD.
  - conflict_count increments once per rising edge of y_denied and saturates at 255.
  - When both denied signals rise in the same cycle, the count increments by 1.
- Reset mid-transfer: flash cs_INV goes high immediately (async). Masters are responsible for retrying.
- enable low mid-transfer: flash cs_INV goes high on the next sysclk edge (via GUARD).

Decomposition:
- Shared package spi_arb_pkg: state encoding constants (ST_IDLE, ST_OWN_DSP, ST_OWN_CPU, ST_GUARD) and the owner ID constants.
- Sub-module sync_ff: SYNC_STAGES-deep reset-to-1 synchroniser, instantiated once per requester cs_INV.

Test Plan:
1. DSP cs_INV low alone, CPU idle -> dsp_grant=1 after 3 sysclk; flash pins follow DSP; cpu_spi_miso=0; on DSP cs high, state 11 for 8 cycles, then 00.
2. Both cs_INV fall in the same cycle after reset with DSP_FIRST=1 -> DSP granted, cpu_denied=1, conflict_count=1. After DSP release plus guard -> CPU granted.
3. Both keep requesting back-to-back for 4 transfers -> grants alternate DSP, CPU, DSP, CPU; conflict_count=4 (one per denied request start).
4. Force 300 denials -> conflict_count saturates at 8'hFF and stays there.
5. DSP holds cs low with TIMEOUT_CYCLES=16 -> timeout_flag=1 at cycle 16, dsp_grant still 1; flag stays 1 after release until reset_INV pulses low.
6. enable drops during OWN_CPU -> next edge state=GUARD, spi_flash_cs_INV=1. Assert reset_INV low mid-transfer -> all outputs take their reset values without waiting for a clock edge.
